// File: rtl/color_box_finder.sv
// color_box_finder: per-frame bounding box of pixels matching a key colour within a tolerance
module color_box_finder #(
  parameter logic [11:0] V_ACT = 12'd720,
  parameter logic [11:0] H_ACT = 12'd1280,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W = 20,
  localparam int V_BITS = $clog2(V_ACT),
  localparam int H_BITS = $clog2(H_ACT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [H_BITS-1:0] x,
  input  logic [V_BITS-1:0] y,
  input  logic              i_de,
  input  logic              i_vsync,
  input  logic [7:0]        i_r,
  input  logic [7:0]        i_g,
  input  logic [7:0]        i_b,
  input  logic [23:0]       key_color,
  input  logic [7:0]        tolerance,
  output logic [H_BITS-1:0] start_x,
  output logic [V_BITS-1:0] start_y,
  output logic [H_BITS-1:0] end_x,
  output logic [V_BITS-1:0] end_y,
  output logic              box_valid,
  output logic              frame_done,
  output logic [CNT_W-1:0]  match_count
);
  localparam logic [H_BITS-1:0] H_MAX = H_BITS'(H_ACT - 12'd1);
  localparam logic [V_BITS-1:0] V_MAX = V_BITS'(V_ACT - 12'd1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state;
  logic [H_BITS-1:0] x_q, min_x, max_x;
  logic [V_BITS-1:0] y_q, min_y, max_y;
  logic [CNT_W-1:0] cnt;
  logic vs_q, vs_qq, hit_q, vs_edge, enough;
  function automatic logic near(input logic [7:0] a, input logic [7:0] b, input logic [7:0] t);
    return ((a > b) ? a - b : b - a) <= t;
  endfunction
  assign vs_edge = vs_q && !vs_qq;
  assign enough = cnt >= CNT_W'(MIN_PIXELS);
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      vs_q <= 1'b0;
      vs_qq <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      x_q <= x;
      y_q <= y;
      vs_q <= i_vsync;
      vs_qq <= vs_q;
      hit_q <= en && i_de && x <= H_MAX && y <= V_MAX &&
               near(i_r, key_color[23:16], tolerance) &&
               near(i_g, key_color[15:8], tolerance) &&
               near(i_b, key_color[7:0], tolerance);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      min_x <= H_MAX;
      min_y <= V_MAX;
      max_x <= '0;
      max_y <= '0;
      cnt <= '0;
      start_x <= '0;
      start_y <= '0;
      end_x <= '0;
      end_y <= '0;
      box_valid <= 1'b0;
      frame_done <= 1'b0;
      match_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (vs_edge) begin
          min_x <= H_MAX;
          min_y <= V_MAX;
          max_x <= '0;
          max_y <= '0;
          cnt <= '0;
          state <= SCAN;
        end
        SCAN: if (vs_edge) state <= COMMIT;
        else if (hit_q) begin
          min_x <= (x_q < min_x) ? x_q : min_x;
          max_x <= (x_q > max_x) ? x_q : max_x;
          min_y <= (y_q < min_y) ? y_q : min_y;
          max_y <= (y_q > max_y) ? y_q : max_y;
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
        end
        COMMIT: begin
          start_x <= enough ? min_x : '0;
          start_y <= enough ? min_y : '0;
          end_x <= enough ? max_x : '0;
          end_y <= enough ? max_y : '0;
          box_valid <= enough;
          match_count <= cnt;
          frame_done <= 1'b1;
          min_x <= H_MAX;
          min_y <= V_MAX;
          max_x <= '0;
          max_y <= '0;
          cnt <= '0;
          state <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_color_box_finder.sv
// tb_color_box_finder: scoreboard bench; expected commits queued with each vsync, checked on frame_done
module tb_color_box_finder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, i_de = 1'b0, i_vsync = 1'b0;
  logic [10:0] x = '0, start_x, end_x;
  logic [9:0] y = '0, start_y, end_y;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0, tolerance = '0;
  logic [23:0] key_color = 24'hFF0000;
  logic box_valid, frame_done, prev_fd = 1'b0;
  logic [19:0] match_count;
  typedef struct {logic [10:0] sx, ex; logic [9:0] sy, ey; logic v; logic [19:0] c;} exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0, n_done = 0, n_exp = 0;
  color_box_finder dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .i_de(i_de), .i_vsync(i_vsync),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .key_color(key_color), .tolerance(tolerance),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .box_valid(box_valid), .frame_done(frame_done), .match_count(match_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (frame_done) begin
      n_done++;
      check("fd_pulse", 32'(prev_fd), 32'd0);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("start_x", 32'(start_x), 32'(e.sx));
        check("start_y", 32'(start_y), 32'(e.sy));
        check("end_x", 32'(end_x), 32'(e.ex));
        check("end_y", 32'(end_y), 32'(e.ey));
        check("box_valid", 32'(box_valid), 32'(e.v));
        check("match_count", 32'(match_count), 32'(e.c));
      end
    end
    prev_fd = frame_done;
  end
  task automatic pix(input int px, input int py, input logic [23:0] c);
    x = 11'(px);
    y = 10'(py);
    {i_r, i_g, i_b} = c;
    i_de = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic vsync(input bit push, input exp_t e);
    if (push) begin
      q.push_back(e);
      n_exp++;
    end
    i_de = 1'b0;
    i_vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    i_vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic rect(input int n);
    int k = 0;
    pix(99, 50, 24'h000000);
    for (int j = 50; j < 54; j++)
      for (int i = 100; i < 110; i++) begin
        if (k < n) pix(i, j, 24'hFF0000);
        k++;
      end
    pix(110, 53, 24'h000000);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_sx"}, 32'(start_x), 0);
    check({tag, "_sy"}, 32'(start_y), 0);
    check({tag, "_ex"}, 32'(end_x), 0);
    check({tag, "_ey"}, 32'(end_y), 0);
    check({tag, "_valid"}, 32'(box_valid), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_count"}, 32'(match_count), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rect(40);
    vsync(0, '{0, 0, 0, 0, 0, 0});
    rect(40);
    vsync(1, '{11'd100, 11'd109, 10'd50, 10'd53, 1'b1, 20'd40});
    rect(15);
    vsync(1, '{0, 0, 0, 0, 1'b0, 20'd15});
    key_color = 24'h808080;
    tolerance = 8'd8;
    pix(20, 20, 24'h898080);
    for (int i = 0; i < 20; i++) pix(5, 5, 24'h888888);
    pix(20, 20, 24'h898080);
    vsync(1, '{11'd5, 11'd5, 10'd5, 10'd5, 1'b1, 20'd20});
    key_color = 24'hFF0000;
    tolerance = 8'd0;
    en = 1'b0;
    rect(40);
    vsync(1, '{0, 0, 0, 0, 1'b0, 20'd0});
    en = 1'b1;
    rect(40);
    vsync(1, '{11'd100, 11'd109, 10'd50, 10'd53, 1'b1, 20'd40});
    pix(1000, 700, 24'hFF0000);
    for (int i = 0; i < 16; i++) pix(1279, 719, 24'hFF0000);
    pix(1280, 719, 24'hFF0000);
    pix(1279, 720, 24'hFF0000);
    vsync(1, '{11'd1000, 11'd1279, 10'd700, 10'd719, 1'b1, 20'd17});
    rect(20);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    i_de = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk);
    #1;
    rect(40);
    vsync(0, '{0, 0, 0, 0, 0, 0});
    for (int i = 7; i < 23; i++) pix(i, 3, 24'hFF0000);
    vsync(1, '{11'd7, 11'd22, 10'd3, 10'd3, 1'b1, 20'd16});
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    check("commits", 32'(n_done), 32'(n_exp));
    check("queue_left", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
